// File: rtl/frame_acc_pkg.sv
// Shared types and width helpers for the frame accumulator.
package frame_acc_pkg;

  typedef enum logic {StEmpty, StFull} state_e;

  localparam int unsigned DefDataW    = 8;
  localparam int unsigned DefFrameLen = 4;
  localparam int unsigned CntW        = $clog2(DefFrameLen);

  // Sized so FRAME_LEN all-ones samples fit exactly.
  function automatic int unsigned sum_width(input int unsigned data_w,
                                            input int unsigned frame_len);
    return data_w + $clog2(frame_len);
  endfunction

  function automatic int unsigned cnt_width(input int unsigned frame_len);
    return $clog2(frame_len);
  endfunction

endpackage

// File: rtl/frame_acc_if.sv
// Sample input and result handshake bundle for the frame accumulator.
interface frame_acc_if
  import frame_acc_pkg::*;
#(
  parameter int unsigned DATA_W    = DefDataW,
  parameter int unsigned FRAME_LEN = DefFrameLen,
  parameter int unsigned SUM_W     = sum_width(DATA_W, FRAME_LEN)
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              out_ready;
  logic              out_valid;
  logic [SUM_W-1:0]  out_sum;
  logic [DATA_W-1:0] out_max;

  modport master (
    output in_valid, in_data, out_ready,
    input  out_valid, out_sum, out_max
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output out_valid, out_sum, out_max
  );
endinterface

// File: rtl/frame_acc_core.sv
// Accumulator datapath: running sum/max, sample count and frame-completion strobe.
module frame_acc_core
  import frame_acc_pkg::*;
#(
  parameter int unsigned DATA_W    = DefDataW,
  parameter int unsigned FRAME_LEN = DefFrameLen,
  parameter int unsigned SUM_W     = sum_width(DATA_W, FRAME_LEN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              done,
  output logic [SUM_W-1:0]  fin_sum,
  output logic [DATA_W-1:0] fin_max
);
  localparam int unsigned CW = cnt_width(FRAME_LEN);
  localparam logic [CW-1:0] LastCnt = CW'(FRAME_LEN - 1);

  logic [SUM_W-1:0]  acc_sum_q, acc_sum_d;
  logic [DATA_W-1:0] acc_max_q, acc_max_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  always_comb begin
    fin_sum   = acc_sum_q + SUM_W'(in_data);
    fin_max   = (in_data > acc_max_q) ? in_data : acc_max_q;
    done      = in_valid && !clear && (cnt_q == LastCnt);
    acc_sum_d = acc_sum_q;
    acc_max_d = acc_max_q;
    cnt_d     = cnt_q;
    // Completion and clear both restart the frame; the final values leave via fin_*.
    if (clear || done) begin
      acc_sum_d = '0;
      acc_max_d = '0;
      cnt_d     = '0;
    end else if (in_valid) begin
      acc_sum_d = fin_sum;
      acc_max_d = fin_max;
      cnt_d     = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_sum_q <= '0;
      acc_max_q <= '0;
      cnt_q     <= '0;
    end else begin
      acc_sum_q <= acc_sum_d;
      acc_max_q <= acc_max_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: rtl/frame_accumulator.sv
// Sums and maxes FRAME_LEN samples; double-buffers the result behind a valid/ready handshake.
module frame_accumulator
  import frame_acc_pkg::*;
#(
  parameter int unsigned DATA_W    = DefDataW,
  parameter int unsigned FRAME_LEN = DefFrameLen,
  parameter int unsigned SUM_W     = sum_width(DATA_W, FRAME_LEN)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  frame_acc_if.slave  bus,
  output logic        overflow,
  output logic [7:0]  drop_cnt
);
  logic              done;
  logic [SUM_W-1:0]  fin_sum;
  logic [DATA_W-1:0] fin_max;

  state_e            state_q, state_d;
  logic [SUM_W-1:0]  out_sum_q, out_sum_d;
  logic [DATA_W-1:0] out_max_q, out_max_d;
  logic              ovf_q, ovf_d;
  logic [7:0]        drop_q, drop_d;

  frame_acc_core #(
    .DATA_W    (DATA_W),
    .FRAME_LEN (FRAME_LEN),
    .SUM_W     (SUM_W)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .in_valid (bus.in_valid),
    .in_data  (bus.in_data),
    .done     (done),
    .fin_sum  (fin_sum),
    .fin_max  (fin_max)
  );

  always_comb begin
    state_d   = state_q;
    out_sum_d = out_sum_q;
    out_max_d = out_max_q;
    ovf_d     = ovf_q;
    drop_d    = drop_q;
    if (clear) begin
      ovf_d = 1'b0;
    end
    unique case (state_q)
      StEmpty: begin
        if (done) begin
          out_sum_d = fin_sum;
          out_max_d = fin_max;
          state_d   = StFull;
        end
      end
      StFull: begin
        if (done) begin
          if (bus.out_ready) begin
            out_sum_d = fin_sum;
            out_max_d = fin_max;
          end else begin
            // Held result wins; the new frame is lost.
            ovf_d = 1'b1;
            if (drop_q != 8'hff) begin
              drop_d = drop_q + 8'd1;
            end
          end
        end else if (bus.out_ready) begin
          state_d = StEmpty;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StEmpty;
      out_sum_q <= '0;
      out_max_q <= '0;
      ovf_q     <= 1'b0;
      drop_q    <= 8'd0;
    end else begin
      state_q   <= state_d;
      out_sum_q <= out_sum_d;
      out_max_q <= out_max_d;
      ovf_q     <= ovf_d;
      drop_q    <= drop_d;
    end
  end

  assign bus.out_valid = (state_q == StFull);
  assign bus.out_sum   = out_sum_q;
  assign bus.out_max   = out_max_q;
  assign overflow      = ovf_q;
  assign drop_cnt      = drop_q;

endmodule

// File: tb/tb_frame_accumulator.sv
// Directed bench for frame_accumulator with a frame-level reference model.
module tb_frame_accumulator;
  localparam int unsigned DW = 8;
  localparam int unsigned FL = 4;
  localparam int unsigned SW = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic       clear;
  logic       overflow;
  logic [7:0] drop_cnt;

  frame_acc_if #(.DATA_W(DW), .FRAME_LEN(FL), .SUM_W(SW)) bus ();

  frame_accumulator #(.DATA_W(DW), .FRAME_LEN(FL), .SUM_W(SW)) dut (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .bus      (bus),
    .overflow (overflow),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference: samples of the open frame, plus the result the consumer should see.
  int q[$];
  int m_pend, m_sum, m_max, m_ovf, m_drop;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_pend = 0; m_sum = 0; m_max = 0; m_ovf = 0; m_drop = 0;
  endtask

  task automatic model_step();
    int comp = 0;
    int s = 0;
    int mx = 0;
    if (clear) begin
      q.delete();
      m_ovf = 0;
    end else if (bus.in_valid) begin
      q.push_back(int'(bus.in_data));
      if (q.size() == FL) begin
        comp = 1;
        foreach (q[i]) begin
          s += q[i];
          if (q[i] > mx) mx = q[i];
        end
        q.delete();
      end
    end
    if (comp != 0) begin
      if (m_pend == 0 || bus.out_ready) begin
        m_pend = 1; m_sum = s; m_max = mx;
      end else begin
        m_ovf = 1;
        if (m_drop < 255) m_drop++;
      end
    end else if (m_pend != 0 && bus.out_ready) begin
      m_pend = 0;
    end
  endtask

  always @(negedge clk) begin
    chk("out_valid", int'(bus.out_valid), m_pend);
    chk("out_sum", int'(bus.out_sum), m_sum);
    chk("out_max", int'(bus.out_max), m_max);
    chk("overflow", int'(overflow), m_ovf);
    chk("drop_cnt", int'(drop_cnt), m_drop);
  end

  task automatic cyc(input logic v, input int d, input logic rdy, input logic clr = 1'b0);
    bus.in_valid  = v;
    bus.in_data   = DW'(d);
    bus.out_ready = rdy;
    clear         = clr;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".valid"}, int'(bus.out_valid), 0);
    chk({tag, ".sum"}, int'(bus.out_sum), 0);
    chk({tag, ".max"}, int'(bus.out_max), 0);
    chk({tag, ".ovf"}, int'(overflow), 0);
    chk({tag, ".drop"}, int'(drop_cnt), 0);
  endtask

  // Reset lands between clock edges; outputs must clear without an edge.
  task automatic async_rst(input string tag);
    bus.in_valid = 1'b0;
    #1;
    rst = 1'b1;
    model_reset();
    #1;
    check_zero(tag);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int t1[4] = '{3, 7, 1, 5};
    int t6[4] = '{4, 3, 2, 1};
    rst = 1'b1;
    clear = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;

    // Sparse strobes, consumer always ready.
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, t1[i], 1'b1);
      if (i == 3) begin
        chk("t1.valid", int'(bus.out_valid), 1);
        chk("t1.sum", int'(bus.out_sum), 16);
        chk("t1.max", int'(bus.out_max), 7);
      end else begin
        repeat (4) cyc(1'b0, 0, 1'b1);
      end
    end
    cyc(1'b0, 0, 1'b1);
    chk("t1.valid_fall", int'(bus.out_valid), 0);

    // Back-to-back full-scale samples.
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 255, 1'b1);
      if (i == 3 || i == 7) begin
        chk("t2.valid", int'(bus.out_valid), 1);
        chk("t2.sum", int'(bus.out_sum), 1020);
        chk("t2.max", int'(bus.out_max), 255);
      end
    end
    cyc(1'b0, 0, 1'b1);
    chk("t2.drop", int'(drop_cnt), 0);

    // Accept and replace in the same cycle.
    repeat (4) cyc(1'b1, 10, 1'b0);
    chk("t4.sum_first", int'(bus.out_sum), 40);
    repeat (3) cyc(1'b1, 20, 1'b0);
    cyc(1'b1, 20, 1'b1);
    chk("t4.valid", int'(bus.out_valid), 1);
    chk("t4.sum", int'(bus.out_sum), 80);
    chk("t4.drop", int'(drop_cnt), 0);
    cyc(1'b0, 0, 1'b1);

    // Stalled consumer: second frame dropped.
    repeat (4) cyc(1'b1, 1, 1'b0);
    repeat (4) cyc(1'b1, 2, 1'b0);
    chk("t3.sum", int'(bus.out_sum), 4);
    chk("t3.ovf", int'(overflow), 1);
    chk("t3.drop", int'(drop_cnt), 1);
    cyc(1'b0, 0, 1'b1);
    chk("t3.valid_fall", int'(bus.out_valid), 0);

    // Clear mid-frame, including a coincident sample.
    cyc(1'b1, 9, 1'b1);
    cyc(1'b1, 9, 1'b1);
    cyc(1'b1, 9, 1'b1, 1'b1);
    for (int i = 1; i <= 4; i++) cyc(1'b1, i, 1'b1);
    chk("t5.sum", int'(bus.out_sum), 10);
    chk("t5.max", int'(bus.out_max), 4);
    chk("t5.ovf", int'(overflow), 0);
    chk("t5.drop", int'(drop_cnt), 1);

    // Clear on the completing sample while FULL: no result, no drop.
    repeat (3) cyc(1'b1, 5, 1'b0);
    cyc(1'b1, 5, 1'b0, 1'b1);
    chk("t5b.sum", int'(bus.out_sum), 10);
    chk("t5b.drop", int'(drop_cnt), 1);
    cyc(1'b0, 0, 1'b1);

    // All-zero frame.
    repeat (4) cyc(1'b1, 0, 1'b1);
    chk("zero.valid", int'(bus.out_valid), 1);
    chk("zero.max", int'(bus.out_max), 0);
    cyc(1'b0, 0, 1'b1);

    // Async reset while FULL, then mid-frame, then a fresh frame.
    repeat (4) cyc(1'b1, 7, 1'b0);
    chk("t6.sum_full", int'(bus.out_sum), 28);
    async_rst("rst_full");
    cyc(1'b1, 6, 1'b0);
    cyc(1'b1, 6, 1'b0);
    async_rst("rst_mid");
    for (int i = 0; i < 4; i++) cyc(1'b1, t6[i], 1'b1);
    chk("t6.valid", int'(bus.out_valid), 1);
    chk("t6.sum", int'(bus.out_sum), 10);
    chk("t6.max", int'(bus.out_max), 4);
    cyc(1'b0, 0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/frame_accumulator.md
Name: frame_accumulator

Overview:
- Downstream consumer of the periodic valid strobe produced by the team's control/timing stage.
- Each strobe carries one unsigned sample. The block sums FRAME_LEN samples and tracks their maximum.
- It presents {sum, max} to the next stage over a valid/ready handshake.
- It is double-buffered: the next frame accumulates while the previous result waits for acceptance. A result that cannot be delivered is dropped and flagged.

Parameters:
- DATA_W, 8, sample width (unsigned).
- FRAME_LEN, 4, samples per frame; legal range 2..256.
- SUM_W, DATA_W+$clog2(FRAME_LEN), sum width; sized so the sum never overflows.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous abort of the frame in progress; clears the overflow flag.
- in_valid  in  1  sample strobe; may be a one-cycle pulse or held high back-to-back.
- in_data  in  DATA_W  sample, qualified by in_valid.
- out_ready  in  1  downstream accepts the result.
- out_valid  out  1  result pending.
- out_sum  out  SUM_W  sum of the frame's samples.
- out_max  out  DATA_W  maximum sample of the frame.
- overflow  out  1  sticky: a completed frame was dropped.
- drop_cnt  out  8  number of dropped frames; saturates at 255.

Behaviour:

Reset (rst=1, asynchronous; takes effect immediately, including mid-frame or mid-handshake):
- acc_sum=0, acc_max=0, sample_cnt=0, state=EMPTY.
- out_valid=0, out_sum=0, out_max=0, overflow=0, drop_cnt=0.

Accumulator (every cycle, in priority order):
- clear=1: acc_sum, acc_max and sample_cnt are set to 0, and overflow is set to 0. A coincident in_valid sample is discarded. The output register, out_valid and drop_cnt are unchanged.
- in_valid=1 and sample_cnt<FRAME_LEN-1: acc_sum+=in_data (zero-extended), acc_max=max(acc_max,in_data), sample_cnt+=1.
- in_valid=1 and sample_cnt==FRAME_LEN-1: the frame completes this cycle.
  - The final sum and max are formed combinationally, including in_data.
  - The accumulator restarts at sum=0, max=0, cnt=0, so back-to-back frames lose no samples.

Output FSM (states EMPTY and FULL):
- EMPTY: out_valid=0. On frame completion, load out_sum/out_max and go to FULL. out_valid=1 in the cycle after the final sample (latency 1).
- FULL: out_valid=1. out_sum and out_max are held stable while out_ready=0.
  - out_ready=1 with no completion: go to EMPTY.
  - Completion with out_ready=1 in the same cycle: the new result replaces the old one and the state stays FULL. No bubble and no drop.
  - Completion with out_ready=0: the new frame is dropped and the held result is preserved. overflow<=1, drop_cnt<=drop_cnt+1 (saturating).
- out_ready is ignored in EMPTY.

Boundaries:
- Sum width: all-ones samples give max sum FRAME_LEN*(2^DATA_W-1), which must fit SUM_W exactly.
- max: sample 0 on every strobe gives out_max=0.
- clear in the same cycle as completion: clear wins. No result is produced and no drop is counted.

Decomposition:
- Package frame_acc_pkg:
  - state enum {EMPTY, FULL};
  - function sum_width(DATA_W, FRAME_LEN);
  - localparam CNT_W=$clog2(FRAME_LEN).
- One sub-module, frame_acc_core: the accumulator datapath (acc_sum, acc_max, sample_cnt, completion strobe and final values).
- The top level holds the output register, FSM, overflow and drop counter.

Test Plan:
- Reset, then pulse in_valid every 5th cycle with data 3,7,1,5 and out_ready=1 -> one cycle after the 4th strobe: out_valid=1, out_sum=16, out_max=7; out_valid=0 the following cycle.
- Back-to-back in_valid=1 with 255 for 8 cycles, out_ready=1 -> two results, each out_sum=1020, out_max=255; no drops.
- out_ready=0, then two frames (1,1,1,1) and (2,2,2,2) -> out_sum stays 4; overflow=1, drop_cnt=1. Then raise out_ready for one cycle -> out_valid falls.
- FULL with out_ready=1 on the same cycle as the next frame's final sample -> out_valid stays 1, out_sum updates to the new frame, drop_cnt=0.
- Assert clear after 2 samples (9,9), then feed 1,2,3,4 -> out_sum=10, out_max=4; overflow cleared.
- Assert rst mid-frame and while FULL -> all outputs 0 immediately, without waiting for a clock edge. The next 4 samples give a correct fresh result.
